// File: rtl/pe_dma_strm_pkg.sv
// ----------------------------------------------------------------------------
// pe_dma_strm_pkg : shared types and default widths for the PE DMA read stream
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pe_dma_strm_pkg;

  localparam int unsigned DMA_ADDR_W = 24;
  localparam int unsigned DMA_DATA_W = 32;
  localparam int unsigned DMA_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } dma_state_e;

  typedef struct packed {
    logic [DMA_ADDR_W-1:0] addr;
    logic [DMA_CNT_W-1:0]  num;
  } dma_desc_t;

endpackage

`default_nettype wire

// File: rtl/pe_dma_rd_fifo.sv
// ----------------------------------------------------------------------------
// pe_dma_rd_fifo : synchronous first-word-fall-through FIFO with eom sideband
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pe_dma_rd_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        push_data_i,
  input  logic                     push_eom_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        head_data_o,
  output logic                     head_eom_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W:0] mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW:0]     count_q;
  logic            wr_en;
  logic            rd_en;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign wr_en   = push_i && !full_o;
  assign rd_en   = pop_i && !empty_o;

  // Head is forced to zero while empty so the lane never shows stale storage.
  assign head_data_o = empty_o ? '0   : mem_q[rd_ptr_q][DATA_W-1:0];
  assign head_eom_o  = empty_o ? 1'b0 : mem_q[rd_ptr_q][DATA_W];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {push_eom_i, push_data_i};
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/pe_dma_strm_rd.sv
// ----------------------------------------------------------------------------
// pe_dma_strm_rd : credit-limited DMA read issue from PE memory onto a stream lane
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pe_dma_strm_rd
  import pe_dma_strm_pkg::*;
#(
  parameter int unsigned ADDR_W     = DMA_ADDR_W,
  parameter int unsigned DATA_W     = DMA_DATA_W,
  parameter int unsigned CNT_W      = DMA_CNT_W,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_poweron,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [CNT_W-1:0]  cfg_num,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_gnt,
  input  logic              mem_rd_dv,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              strm_valid,
  input  logic              strm_ready,
  output logic [DATA_W-1:0] strm_data,
  output logic              strm_eom,
  output logic              done
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  dma_state_e       state_q, state_d;
  dma_desc_t        desc_q, desc_d;
  logic [CNT_W-1:0] issue_left_q, issue_left_d;
  logic [CNT_W-1:0] sent_q, sent_d;
  logic [CNT_W-1:0] recv_q, recv_d;
  logic [CW-1:0]    outst_q, outst_d;

  logic [CW-1:0]    fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             head_eom;
  logic [CNT_W-1:0] num_w;
  logic             cfg_fire;
  logic             gnt_fire;
  logic             push;
  logic             pop;
  logic             credit;
  logic             last_sent;
  logic             last_recv;

  assign num_w     = CNT_W'(desc_q.num);
  assign cfg_ready = (state_q == ST_IDLE) && !reset_poweron;
  assign cfg_fire  = cfg_valid && cfg_ready;

  // Words in flight plus words buffered may never exceed the FIFO depth,
  // because memory returns cannot be back-pressured.
  assign credit     = ({1'b0, outst_q} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH);
  assign mem_rd_req = (state_q == ST_ISSUE) && credit;
  assign mem_rd_addr = ADDR_W'(desc_q.addr);
  assign gnt_fire   = mem_rd_req && mem_rd_gnt;

  assign push       = mem_rd_dv && (outst_q != '0) && !fifo_full;
  assign strm_valid = !fifo_empty;
  assign pop        = strm_valid && strm_ready;
  assign last_recv  = (recv_q == num_w - CNT_W'(1));
  assign last_sent  = (sent_q == num_w - CNT_W'(1));
  assign strm_eom   = strm_valid && head_eom && last_sent;
  assign done       = (state_q == ST_DONE);

  always_comb begin
    state_d      = state_q;
    desc_d       = desc_q;
    issue_left_d = issue_left_q;
    sent_d       = sent_q;
    recv_d       = recv_q;
    outst_d      = outst_q;

    case ({gnt_fire, push})
      2'b10:   outst_d = outst_q + CW'(1);
      2'b01:   outst_d = outst_q - CW'(1);
      default: outst_d = outst_q;
    endcase

    if (gnt_fire) begin
      desc_d.addr  = desc_q.addr + DMA_ADDR_W'(1);
      issue_left_d = issue_left_q - CNT_W'(1);
    end
    if (push) begin
      recv_d = recv_q + CNT_W'(1);
    end
    if (pop) begin
      sent_d = sent_q + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (cfg_fire) begin
          desc_d.addr  = DMA_ADDR_W'(cfg_addr);
          desc_d.num   = DMA_CNT_W'(cfg_num);
          issue_left_d = cfg_num;
          sent_d       = '0;
          recv_d       = '0;
          state_d      = (cfg_num == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (gnt_fire && (issue_left_q == CNT_W'(1))) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && last_sent) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      state_q      <= ST_IDLE;
      desc_q       <= '0;
      issue_left_q <= '0;
      sent_q       <= '0;
      recv_q       <= '0;
      outst_q      <= '0;
    end else begin
      state_q      <= state_d;
      desc_q       <= desc_d;
      issue_left_q <= issue_left_d;
      sent_q       <= sent_d;
      recv_q       <= recv_d;
      outst_q      <= outst_d;
    end
  end

  pe_dma_rd_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_i       (reset_poweron),
    .push_i      (push),
    .push_data_i (mem_rd_data),
    .push_eom_i  (last_recv),
    .pop_i       (pop),
    .head_data_o (strm_data),
    .head_eom_o  (head_eom),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

endmodule

`default_nettype wire
